// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the multiplexed 4-digit 7-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
`timescale 1ns/1ps
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef logic [3:0] bcd_digit_t;

    // Everything that goes to the board pins for one digit slot.
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } display_t;

    localparam display_t DISPLAY_DARK = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};

    // Active-low one-hot anode select for a digit position.
    function automatic logic [3:0] anode_for(input logic [1:0] index);
        return ~(4'b0001 << index);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD nibble to active-low segment pattern; non-decimal nibbles show a dash.
`timescale 1ns/1ps
module bcd_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 4-digit multiplexed 7-segment display from a packed BCD word, with
// per-frame shadowing, leading-zero blanking, decimal points and whole-display blink.
`timescale 1ns/1ps
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int DIGIT_HZ   = 4_000,
    parameter int BLINK_HZ   = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    input  logic        blink,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int DIGIT_TICK = CLOCK_FREQ / DIGIT_HZ;
    localparam int BLINK_HALF = CLOCK_FREQ / (2 * BLINK_HZ);
    localparam int DIV_W      = (DIGIT_TICK > 1) ? $clog2(DIGIT_TICK) : 1;
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIGIT_TICK - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [DIV_W-1:0]   div_reg, div_next;
    logic [1:0]         index_reg, index_next;
    logic [15:0]        shadow_reg, shadow_next;
    logic               enable_d_reg;
    logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic               phase_on_reg, phase_on_next;
    display_t           disp_reg, disp_next;
    logic               frame_done_reg, frame_done_next;

    logic               div_last;
    logic               wrap;
    logic               enable_rise;
    logic               show;
    logic [15:0]        frame_word;

    bcd_digit_t         digit_nib  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] lz_run;
    logic [NUM_DIGITS-1:0] blank_flag;

    bcd_digit_t         sel_nib;
    logic               sel_blank;
    logic [6:0]         dec_pattern;

    // ------------------------------------------------------------------
    // Digit divider and scan index
    // ------------------------------------------------------------------
    assign div_last    = (div_reg == DIV_LAST);
    assign wrap        = enable && div_last && (index_reg == 2'd3);
    assign enable_rise = enable && !enable_d_reg;

    always_comb begin
        div_next   = div_reg;
        index_next = index_reg;
        if (!enable) begin
            div_next   = '0;
            index_next = '0;
        end else if (div_last) begin
            div_next   = '0;
            index_next = index_reg + 2'd1;
        end else begin
            div_next   = div_reg + DIV_W'(1);
        end
    end

    // The shadow only changes at frame boundaries (or on wake-up), so a frame never tears.
    assign shadow_next = (wrap || enable_rise) ? bcd_in : shadow_reg;

    // On the wake-up cycle digit 0 is rendered from the word being latched, not the stale shadow.
    assign frame_word = enable_rise ? bcd_in : shadow_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg      <= '0;
            index_reg    <= '0;
            shadow_reg   <= '0;
            enable_d_reg <= 1'b0;
        end else begin
            div_reg      <= div_next;
            index_reg    <= index_next;
            shadow_reg   <= shadow_next;
            enable_d_reg <= enable;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking: a digit is blank when it and every digit to
    // its left are zero; the rightmost digit always shows.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_nib[gi]  = frame_word[gi*4 +: 4];
            assign digit_zero[gi] = (frame_word[gi*4 +: 4] == 4'd0);

            if (gi == NUM_DIGITS - 1) begin : g_msd
                assign lz_run[gi] = digit_zero[gi];
            end else begin : g_lower
                assign lz_run[gi] = lz_run[gi+1] && digit_zero[gi];
            end

            if (gi == 0) begin : g_lsd
                assign blank_flag[gi] = 1'b0;
            end else begin : g_upper
                assign blank_flag[gi] = blank_lz && lz_run[gi];
            end
        end
    endgenerate

    assign sel_nib   = digit_nib[index_reg];
    assign sel_blank = blank_flag[index_reg];

    bcd_to_seg7 u_decode (
        .nibble  (sel_nib),
        .pattern (dec_pattern)
    );

    // ------------------------------------------------------------------
    // Blink phase: free-runs only while blink is held; dropping blink
    // returns to the on phase and un-darkens the anodes on the very next edge.
    // ------------------------------------------------------------------
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        phase_on_next  = phase_on_reg;
        if (!blink) begin
            blink_cnt_next = '0;
            phase_on_next  = 1'b1;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_on_next  = !phase_on_reg;
        end else begin
            blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
        end
    end

    assign show = !blink || phase_on_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_reg <= '0;
            phase_on_reg  <= 1'b1;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            phase_on_reg  <= phase_on_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered pin drive
    // ------------------------------------------------------------------
    always_comb begin
        disp_next       = DISPLAY_DARK;
        frame_done_next = wrap;
        if (enable) begin
            disp_next.an  = show ? anode_for(index_reg) : AN_OFF;
            disp_next.seg = sel_blank ? SEG_BLANK : dec_pattern;
            disp_next.dp  = !dp_mask[index_reg];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_reg       <= DISPLAY_DARK;
            frame_done_reg <= 1'b0;
        end else begin
            disp_reg       <= disp_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign an         = disp_reg.an;
    assign seg        = disp_reg.seg;
    assign dp         = disp_reg.dp;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios then random traffic, every cycle
// compared against a frame/time-based reference model of the display.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic        blink;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .CLOCK_FREQ (400),
        .DIGIT_HZ   (100),
        .BLINK_HZ   (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .blank_lz   (blank_lz),
        .blink      (blink),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // Reference model: n counts clock edges since the display woke up; each digit
    // dwells 4 edges, a frame is 16 edges, and the word shown in a frame is the
    // bcd_in sampled on the last edge of the previous frame (or on wake-up).
    localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam int TICK = 4;
    localparam int HALF = 20;

    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;
    int          n;
    bit          active;
    logic [15:0] word;
    int          m;

    task automatic model_reset();
        active  = 1'b0;
        n       = 0;
        m       = 0;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        exp_fd  = 1'b0;
    endtask

    task automatic model_edge();
        bit         lit;
        int         d;
        logic [3:0] nib;
        bit         blanked;
        if (reset) begin
            model_reset();
            return;
        end
        lit = !blink || ((m / HALF) % 2 == 0);
        m   = blink ? m + 1 : 0;
        if (!enable) begin
            active  = 1'b0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_fd  = 1'b0;
        end else begin
            if (!active) begin
                active = 1'b1;
                n      = 0;
                word   = bcd_in;
            end else begin
                n = n + 1;
            end
            d   = (n / TICK) % 4;
            nib = word[d*4 +: 4];
            blanked = 1'b0;
            if (blank_lz && d > 0) begin
                blanked = 1'b1;
                for (int k = 3; k >= d; k--)
                    if (word[k*4 +: 4] != 4'd0) blanked = 1'b0;
            end
            exp_seg = blanked ? 7'h7F : ((nib > 4'd9) ? 7'h3F : PAT[int'(nib)]);
            exp_dp  = !dp_mask[d];
            exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
            exp_fd  = ((n % 16) == 15);
            if ((n % 16) == 15) word = bcd_in;
        end
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (an === exp_an) else begin
            errors++;
            $error("FAIL %s an observed=%h expected=%h t=%0t", tag, an, exp_an, $time);
        end
        checks++;
        assert (seg === exp_seg) else begin
            errors++;
            $error("FAIL %s seg observed=%h expected=%h t=%0t", tag, seg, exp_seg, $time);
        end
        checks++;
        assert (dp === exp_dp) else begin
            errors++;
            $error("FAIL %s dp observed=%b expected=%b t=%0t", tag, dp, exp_dp, $time);
        end
        checks++;
        assert (frame_done === exp_fd) else begin
            errors++;
            $error("FAIL %s frame_done observed=%b expected=%b t=%0t", tag, frame_done, exp_fd, $time);
        end
    endtask

    // One clock: model the edge, then compare shortly after it.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int k = 0; k < 4; k++)
            w[k*4 +: 4] = ($urandom_range(0, 7) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
        return w;
    endfunction

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        bcd_in   = 16'h0000;
        blank_lz = 1'b0;
        blink    = 1'b0;
        dp_mask  = 4'b0000;
        model_reset();
        #1;
        check_all("reset_state");
        run("reset_hold", 2);
        reset = 1'b0;
        run("idle", 3);

        // Plain scan of 1234, no blanking.
        bcd_in = 16'h1234;
        enable = 1'b1;
        run("scan_1234", 40);

        // Leading-zero blanking.
        bcd_in   = 16'h0005;
        blank_lz = 1'b1;
        run("lz_0005", 36);
        bcd_in = 16'h0105;
        run("lz_0105", 32);

        // Invalid nibble and decimal point.
        blank_lz = 1'b0;
        bcd_in   = 16'h12A4;
        dp_mask  = 4'b0100;
        run("dash_dp", 32);

        // Mid-frame change must wait for the frame boundary.
        dp_mask = 4'b0000;
        bcd_in  = 16'h1111;
        run("tear_pre", 22);
        bcd_in = 16'h2222;
        run("tear_post", 30);

        // Blink, then drop it during an off phase.
        blink = 1'b1;
        run("blink", 90);
        run("blink_off", 25);
        blink = 1'b0;
        step("blink_drop");
        run("blink_after", 8);

        // Reset while digit 2 is selected.
        for (int i = 0; i < 20 && !(active && ((n / TICK) % 4) == 2); i++)
            step("to_digit2");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        run("reset_mid", 3);
        reset = 1'b0;
        run("after_reset", 20);

        // Enable drop mid-frame.
        run("pre_disable", 6);
        enable = 1'b0;
        run("disabled", 20);
        enable = 1'b1;
        bcd_in = 16'h0907;
        run("reenable", 20);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) bcd_in = rand_word();
            if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) blank_lz = !blank_lz;
            if ($urandom_range(0, 59) == 0) blink = !blink;
            if ($urandom_range(0, 99) == 0) enable = !enable;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
